// File: rtl/hilo_muldiv_unit.sv
// Purpose: multi-cycle MULT/MULTU/DIV/DIVU unit owning the HI/LO pair, plus MTHI/MTLO writes.
// Latency: WIDTH+1 cycles from Start to Done (MULDIV_EARLY_TERM_EN shortens multiplies to iterations+1).
// Backpressure: none; Busy is held for the whole operation and Start/writes are ignored while Busy.
module hilo_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic [1:0]         i_op,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  input  logic               i_write_hi,
  input  logic               i_write_lo,
  input  logic [WIDTH-1:0]   i_write_data,
  output logic               o_busy,
  output logic               o_done,
  output logic [WIDTH-1:0]   o_hi,
  output logic [WIDTH-1:0]   o_lo,
  output logic [2*WIDTH-1:0] o_hilo,
  output logic               o_div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0]   ONE_W  = WIDTH'(1);
  localparam logic [2*WIDTH-1:0] ONE_2W = (2*WIDTH)'(1);
  localparam logic [CW-1:0]      ONE_C  = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t             r_state;
  logic [1:0]         r_op;       // bit1: divide, bit0: signed
  logic               r_sign_a;
  logic               r_sign_b;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_acc;      // multiply: product accumulator; divide: low half is remainder
  logic [2*WIDTH-1:0] r_mcand;    // multiply: multiplicand magnitude, shifted left each step
  logic [WIDTH-1:0]   r_q;        // multiply: multiplier (shifted right); divide: dividend -> quotient
  logic [WIDTH-1:0]   r_b;        // divisor magnitude (also used for the divide-by-zero test)
  logic [WIDTH-1:0]   r_a_raw;    // A as presented, returned in HI on divide by zero
  logic               r_busy;
  logic               r_done;
  logic               r_dbz;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  // Operand magnitudes at launch; sign only matters for the signed ops.
  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;

  assign w_a_neg = i_op[0] & i_a[WIDTH-1];
  assign w_b_neg = i_op[0] & i_b[WIDTH-1];
  assign w_a_mag = w_a_neg ? (~i_a + ONE_W) : i_a;
  assign w_b_mag = w_b_neg ? (~i_b + ONE_W) : i_b;

  // One shift-add multiply step.
  logic [2*WIDTH-1:0] w_acc_add;
  logic [WIDTH-1:0]   w_q_shr;

  assign w_acc_add = r_q[0] ? (r_acc + r_mcand) : r_acc;
  assign w_q_shr   = r_q >> 1;

  // One restoring divide step: shift remainder:quotient left, trial subtract.
  logic [WIDTH:0]     w_shift;
  logic [WIDTH:0]     w_sub;
  logic               w_ge;
  logic [WIDTH-1:0]   w_rem_next;
  logic [WIDTH-1:0]   w_quo_next;

  assign w_shift    = {r_acc[WIDTH-1:0], r_q[WIDTH-1]};
  assign w_sub      = w_shift - {1'b0, r_b};
  assign w_ge       = (w_shift >= {1'b0, r_b});
  assign w_rem_next = w_ge ? w_sub[WIDTH-1:0] : w_shift[WIDTH-1:0];
  assign w_quo_next = {r_q[WIDTH-2:0], w_ge};

  // Last iteration detect; early termination only applies to multiplies.
  logic w_last;
`ifdef MULDIV_EARLY_TERM_EN
  assign w_last = r_op[1] ? (r_cnt == ONE_C) : (w_q_shr == '0);
`else
  assign w_last = (r_cnt == ONE_C);
`endif

  // Sign correction applied in FIX.
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;
  logic               w_dbz;

  assign w_prod = (r_sign_a ^ r_sign_b) ? (~r_acc + ONE_2W) : r_acc;
  assign w_quo  = (r_sign_a ^ r_sign_b) ? (~r_q + ONE_W) : r_q;
  assign w_rem  = r_sign_a ? (~r_acc[WIDTH-1:0] + ONE_W) : r_acc[WIDTH-1:0];
  assign w_dbz  = r_op[1] & (r_b == '0);

  // Control FSM, datapath iteration and HI/LO ownership.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_op     <= 2'b00;
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_q      <= '0;
      r_b      <= '0;
      r_a_raw  <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_dbz    <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          r_dbz  <= 1'b0;
          // Direct writes commit even when an operation launches this cycle;
          // the operation result overwrites them later.
          if (i_write_hi) r_hi <= i_write_data;
          if (i_write_lo) r_lo <= i_write_data;
          if (i_start) begin
            r_op     <= i_op;
            r_sign_a <= w_a_neg;
            r_sign_b <= w_b_neg;
            r_cnt    <= CW'(WIDTH);
            r_acc    <= '0;
            r_mcand  <= {{WIDTH{1'b0}}, w_a_mag};
            r_q      <= i_op[1] ? w_a_mag : w_b_mag;
            r_b      <= w_b_mag;
            r_a_raw  <= i_a;
            r_busy   <= 1'b1;
            r_state  <= S_RUN;
          end
        end
        S_RUN: begin
          r_cnt <= r_cnt - ONE_C;
          if (r_op[1]) begin
            r_acc <= {{WIDTH{1'b0}}, w_rem_next};
            r_q   <= w_quo_next;
          end else begin
            r_acc   <= w_acc_add;
            r_mcand <= r_mcand << 1;
            r_q     <= w_q_shr;
          end
          if (w_last) r_state <= S_FIX;
        end
        S_FIX: begin
          if (!r_op[1]) begin
            r_hi <= w_prod[2*WIDTH-1:WIDTH];
            r_lo <= w_prod[WIDTH-1:0];
          end else if (w_dbz) begin
            r_hi <= r_a_raw;
            r_lo <= '1;
          end else begin
            r_hi <= w_rem;
            r_lo <= w_quo;
          end
          r_dbz   <= w_dbz;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_hi          = r_hi;
  assign o_lo          = r_lo;
  assign o_hilo        = {r_hi, r_lo};
  assign o_div_by_zero = r_dbz;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Bench for hilo_muldiv_unit: directed steps plus randomized operations
// checked against a plain-arithmetic model of the HI/LO results and latency.
module tb_hilo_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        write_hi;
  logic        write_lo;
  logic [31:0] write_data;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [63:0] hilo;
  logic        dbz;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  hilo_muldiv_unit #(.WIDTH(32)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_start      (start),
    .i_op         (op),
    .i_a          (a),
    .i_b          (b),
    .i_write_hi   (write_hi),
    .i_write_lo   (write_lo),
    .i_write_data (write_data),
    .o_busy       (busy),
    .o_done       (done),
    .o_hi         (hi),
    .o_lo         (lo),
    .o_hilo       (hilo),
    .o_div_by_zero(dbz)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference result: {HI,LO} from plain 64-bit arithmetic.
  function automatic logic [63:0] ref_hilo(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, q, r;
    logic [63:0] res;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      2'd0: res = {32'd0, x} * {32'd0, y};
      2'd1: res = sx * sy;
      default: begin
        if (y == 32'd0) res = {x, 32'hFFFF_FFFF};
        else if (o == 2'd2) res = {x % y, x / y};
        else begin
          q = sx / sy;
          r = sx % sy;
          res = {r[31:0], q[31:0]};
        end
      end
    endcase
    return res;
  endfunction

  // Reference latency in cycles from the Start edge to Done visible.
  function automatic int ref_lat(input logic [1:0] o, input logic [31:0] y);
    int lat;
    lat = 33;
`ifdef MULDIV_EARLY_TERM_EN
    if (!o[1]) begin
      logic [31:0] mag;
      int iters;
      mag = (o == 2'd1 && y[31]) ? -y : y;
      iters = 1;
      for (int i = 0; i < 32; i++) if (mag[i]) iters = i + 1;
      lat = iters + 1;
    end
`endif
    return lat;
  endfunction

  // Launch one operation, wait for Done (bounded) and check everything.
  // disturb>0: pulse Start(A=1,B=1) and WriteHi so they are sampled at that cycle.
  // mthi: assert WriteHi in the same cycle as Start.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, input int disturb, input bit mthi);
    logic [63:0] exp;
    int n;
    bit busy_bad;
    exp = ref_hilo(o, x, y);
    start = 1'b1; op = o; a = x; b = y;
    if (mthi) begin write_hi = 1'b1; write_data = 32'h0000_1234; end
    tick();
    start = 1'b0; write_hi = 1'b0;
    if (mthi) check({tag, "_mthi_commit"}, {32'd0, hi}, 64'h1234);
    n = 0;
    busy_bad = 1'b0;
    while (!done && n < 100) begin
      if (!busy) busy_bad = 1'b1;
      if (disturb > 0 && n == disturb - 1) begin
        start = 1'b1; a = 32'd1; b = 32'd1; write_hi = 1'b1; write_data = 32'hAAAA_5555;
      end
      if (disturb > 0 && n == disturb) begin
        start = 1'b0; write_hi = 1'b0;
      end
      tick();
      n++;
    end
    start = 1'b0; write_hi = 1'b0;
    check({tag, "_latency"}, 64'(n), 64'(ref_lat(o, y)));
    check({tag, "_busy_window"}, {63'd0, busy_bad}, 64'd0);
    check({tag, "_hilo"}, hilo, exp);
    check({tag, "_hi_lo"}, {hi, lo}, exp);
    check({tag, "_flags"}, {62'd0, busy, dbz}, {62'd0, 1'b0, (o[1] && y == 32'd0)});
    tick();
    check({tag, "_pulse_end"}, {61'd0, busy, done, dbz}, 64'd0);
  endtask

  initial begin
    bit seen_done;
    rst = 1'b1; start = 1'b0; op = 2'd0; a = '0; b = '0;
    write_hi = 1'b0; write_lo = 1'b0; write_data = '0;

    // Reset then idle: everything reads zero.
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("reset_hilo", hilo, 64'd0);
      check("reset_flags", {32'd0, 29'd0, busy, done, dbz}, 64'd0);
      tick();
    end

    // Directed operations.
    run_op("mult_neg3x7", 2'd1, 32'hFFFF_FFFD, 32'd7, 0, 1'b0);
    check("mult_neg3x7_value", hilo, 64'hFFFF_FFFF_FFFF_FFEB);
    run_op("div_neg7by2", 2'd3, 32'hFFFF_FFF9, 32'd2, 0, 1'b0);
    check("div_neg7by2_value", hilo, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op("divu_by0", 2'd2, 32'h1234_5678, 32'd0, 0, 1'b0);
    run_op("div_by0", 2'd3, 32'h8000_0001, 32'd0, 0, 1'b0);
    run_op("div_ovf", 2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
    check("div_ovf_value", hilo, 64'h0000_0000_8000_0000);
    run_op("div_rem_sign", 2'd3, 32'd7, 32'hFFFF_FFFE, 0, 1'b0);
    run_op("multu_busy_ign", 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 10, 1'b0);
    check("multu_busy_ign_value", hilo, 64'hFFFF_FFFE_0000_0001);
    seen_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done || busy) seen_done = 1'b1;
      tick();
    end
    check("multu_busy_ign_single_done", {63'd0, seen_done}, 64'd0);
    run_op("multu_5x3", 2'd0, 32'd5, 32'd3, 0, 1'b0);
    check("multu_5x3_value", hilo, 64'd15);
    run_op("mult_by0", 2'd1, 32'h8000_0000, 32'd0, 0, 1'b0);
    run_op("mult_negb", 2'd1, 32'd9, 32'hFFFF_FFF0, 0, 1'b0);
    run_op("mthi_with_start", 2'd0, 32'd6, 32'd7, 0, 1'b1);
    check("mthi_with_start_value", hilo, 64'd42);

    // Reset in the middle of a DIVU.
    start = 1'b1; op = 2'd2; a = 32'hDEAD_BEEF; b = 32'd3;
    tick();
    start = 1'b0;
    for (int i = 0; i < 14; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_hilo", hilo, 64'd0);
    check("midrst_flags", {61'd0, busy, done, dbz}, 64'd0);
    seen_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done || busy) seen_done = 1'b1;
      tick();
    end
    check("midrst_no_done", {63'd0, seen_done}, 64'd0);

    // MTLO, MTHI, and both together in IDLE.
    write_lo = 1'b1; write_data = 32'h55;
    tick();
    write_lo = 1'b0;
    check("mtlo", hilo, 64'h0000_0000_0000_0055);
    write_hi = 1'b1; write_data = 32'h0BAD_F00D;
    tick();
    write_hi = 1'b0;
    check("mthi", hilo, 64'h0BAD_F00D_0000_0055);
    write_hi = 1'b1; write_lo = 1'b1; write_data = 32'hCAFE_BABE;
    tick();
    write_hi = 1'b0; write_lo = 1'b0;
    check("mthi_mtlo", hilo, 64'hCAFE_BABE_CAFE_BABE);

    // Randomized operations against the model.
    for (int i = 0; i < 40; i++) begin
      logic [1:0]  ro;
      logic [31:0] ra, rb;
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(0, 15));
        2: rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      run_op("random", ro, ra, rb, 0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hilo_muldiv_unit.md
Name: hilo_muldiv_unit

Overview:
- Multi-cycle multiply/divide unit that owns the HI/LO register pair.
- Produces the 64-bit {HI,LO} word consumed by the downstream 64-bit 2:1 selector in the EX stage.
- Handles MULT/MULTU/DIV/DIVU with a shift-add multiplier and a restoring divider.
- Handles MTHI/MTLO direct writes; the hazard unit stalls on Busy.

Parameters:
- WIDTH, 32, operand width; HI, LO and HiLo widths derive from it (HiLo = 2*WIDTH).

Ports:
- Clk  in  1  rising-edge clock
- Rst  in  1  synchronous, active-high reset
- Start  in  1  launch operation; sampled only in IDLE
- Op  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV
- A  in  WIDTH  multiplicand / dividend
- B  in  WIDTH  multiplier / divisor
- WriteHi  in  1  MTHI write enable
- WriteLo  in  1  MTLO write enable
- WriteData  in  WIDTH  MTHI/MTLO data
- Busy  out  1  operation in progress
- Done  out  1  one-cycle completion pulse
- Hi  out  WIDTH  HI register
- Lo  out  WIDTH  LO register
- HiLo  out  2*WIDTH  {Hi,Lo}
- DivByZero  out  1  pulses with Done when a divide had B==0

Behaviour:
- Reset: Rst sampled high at a Clk edge clears every output (Busy, Done, Hi, Lo, HiLo, DivByZero) and returns the FSM to IDLE.
  - Rst mid-operation abandons the operation; no Done is produced.
- All outputs are registered.
- States: IDLE, RUN, FIX.
- IDLE:
  - Start=1 latches Op, sign flags, |A| and |B| (magnitudes for signed ops, raw for unsigned).
  - Loads iteration counter = WIDTH, sets Busy=1, moves to RUN.
  - Start=0 stays in IDLE.
- RUN: one iteration per edge; counter decrements; moves to FIX after the WIDTH-th iteration.
  - Multiply: shift-add over a 2*WIDTH accumulator, LSB-first on the multiplier.
  - Divide: restoring; shift remainder:quotient left, trial subtract divisor, set quotient bit if non-negative.
- FIX:
  - Applies sign correction and writes Hi/Lo.
  - Sets Done=1 (and DivByZero when applicable) and Busy=0, then moves to IDLE.
  - Done is high exactly one cycle.
- Latency: Start sampled at edge E0; Done, Busy=0 and new Hi/Lo all visible after edge E(WIDTH+1), i.e. 33 cycles for WIDTH=32.
- Multiply results:
  - {Hi,Lo} = full 2*WIDTH product.
  - MULT negates the product if the operand signs differ.
- Divide results:
  - Lo = quotient, Hi = remainder.
  - DIV truncates the quotient toward zero; the remainder takes the dividend's sign.
  - Signed overflow 0x80000000 / 0xFFFFFFFF gives Lo=0x80000000, Hi=0.
- Divide by zero (DIV or DIVU): full latency, Lo=all ones, Hi=A as presented at Start, DivByZero=1 with Done.
- Start while Busy: ignored; the in-flight operation is unaffected.
- WriteHi/WriteLo:
  - In IDLE, the register takes WriteData at the next edge.
  - While Busy, ignored.
  - In IDLE with Start in the same cycle, the write commits and the operation launches; the operation result later overwrites both Hi and Lo.
- WriteHi and WriteLo together write WriteData into both registers.
- HiLo always equals {Hi,Lo}.

Optional Feature:
- Macro: MULDIV_EARLY_TERM_EN.
- Defined: for MULT/MULTU, RUN moves to FIX on the edge where the remaining unshifted multiplier magnitude becomes zero.
  - Iterations = max(1, bit index of the MS one of |B| + 1).
  - Latency = iterations + 1.
  - B==0 takes 1 iteration.
  - Divides are unchanged.
- Undefined: every operation takes fixed WIDTH iterations (latency WIDTH+1).

Test Plan:
- Rst=1 one edge, then idle 5 cycles -> Busy=0, Done=0, Hi=Lo=0, HiLo=0, DivByZero=0 throughout.
- MULT A=0xFFFFFFFD (-3), B=7 -> Done pulse exactly 33 cycles after Start; HiLo=0xFFFFFFFF_FFFFFFEB; Busy high for cycles 1..32.
- DIV A=-7 (0xFFFFFFF9), B=2 -> Lo=0xFFFFFFFD (-3), Hi=0xFFFFFFFF (-1).
- DIVU A=0x12345678, B=0 -> Lo=0xFFFFFFFF, Hi=0x12345678, DivByZero=1 with Done, 0 the next cycle.
- Start MULTU 0xFFFFFFFF x 0xFFFFFFFF, then pulse Start (A=1, B=1) and WriteHi (0xAAAA5555) at cycle 10 -> both ignored; HiLo=0xFFFFFFFE_00000001; single Done.
- Rst asserted at cycle 15 of a DIVU -> next cycle all outputs 0, no Done. Then MTLO 0x55 in IDLE -> Lo=0x55, Hi=0.
- With MULDIV_EARLY_TERM_EN: MULTU A=5, B=3 -> Done 3 cycles after Start, HiLo=15.
  - Without the macro, the same stimulus gives Done after 33 cycles.
